// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - shared scan states, pin constants and digit segment patterns
package display_pkg;

    typedef enum logic {
        S_ONES = 1'b0,
        S_TENS = 1'b1
    } scan_state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [1:0] AN_OFF    = 2'b11;
    localparam logic [1:0] AN_ONES   = 2'b10;
    localparam logic [1:0] AN_TENS   = 2'b01;

    // Active-low {g,f,e,d,c,b,a} patterns for digits 0..9
    localparam logic [0:9][6:0] SEG_DIGITS = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };

endpackage

// File: rtl/seg7_decoder.sv
// rtl/seg7_decoder.sv - combinational BCD digit to active-low seven-segment pattern
module seg7_decoder
    import display_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    // Codes 10..15 are not digits and show nothing
    always_comb begin
        seg = SEG_BLANK;
        case (digit)
            4'd0:    seg = SEG_DIGITS[0];
            4'd1:    seg = SEG_DIGITS[1];
            4'd2:    seg = SEG_DIGITS[2];
            4'd3:    seg = SEG_DIGITS[3];
            4'd4:    seg = SEG_DIGITS[4];
            4'd5:    seg = SEG_DIGITS[5];
            4'd6:    seg = SEG_DIGITS[6];
            4'd7:    seg = SEG_DIGITS[7];
            4'd8:    seg = SEG_DIGITS[8];
            4'd9:    seg = SEG_DIGITS[9];
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/count_seg_display.sv
// rtl/count_seg_display.sv - two-digit multiplexed display of a 4-bit count with wrap flash
module count_seg_display
    import display_pkg::*;
#(
    parameter int REFRESH_DIV = 50000,
    parameter int WRAP_FLASH  = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] count,
    output logic [6:0] seg,
    output logic [1:0] an,
    output logic       dp
);

    localparam int              DIV_W    = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);
    localparam logic [3:0]      FLASH_LOAD = 4'(WRAP_FLASH);

    logic [3:0]       count_q;
    logic [DIV_W-1:0] div_cnt;
    scan_state_t      state;
    logic [3:0]       ones_l;
    logic             tens_l;
    logic [3:0]       flash_cnt;

    logic             tick;
    logic             boundary;
    logic             wrap;
    logic [3:0]       digit_sel;
    logic [6:0]       dec_seg;

    assign tick     = (div_cnt == DIV_LAST);
    assign boundary = tick && (state == S_TENS);
    assign wrap     = (count_q == 4'hF) && (count == 4'h0);

    // The tens slot can only ever show a 1, so the decoder is shared between slots
    assign digit_sel = (state == S_ONES) ? ones_l : 4'd1;

    seg7_decoder u_dec (
        .digit (digit_sel),
        .seg   (dec_seg)
    );

    // Input sample, prescaler, scan FSM, frame-aligned digit latch, flash timer and pin register
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q   <= 4'd0;
            div_cnt   <= '0;
            state     <= S_ONES;
            ones_l    <= 4'd0;
            tens_l    <= 1'b0;
            flash_cnt <= 4'd0;
            seg       <= SEG_BLANK;
            an        <= AN_OFF;
            dp        <= 1'b1;
        end else begin
            count_q <= count;
            div_cnt <= tick ? '0 : div_cnt + 1'b1;

            if (tick) begin
                state <= (state == S_ONES) ? S_TENS : S_ONES;
            end

            // Digits only change between frames so a frame never mixes two values
            if (boundary) begin
                if (count_q >= 4'd10) begin
                    tens_l <= 1'b1;
                    ones_l <= count_q - 4'd10;
                end else begin
                    tens_l <= 1'b0;
                    ones_l <= count_q;
                end
            end

            // A wrap always (re)starts the flash, even on a frame boundary
            if (wrap) begin
                flash_cnt <= FLASH_LOAD;
            end else if (boundary && (flash_cnt != 4'd0)) begin
                flash_cnt <= flash_cnt - 4'd1;
            end

            case (state)
                S_ONES: begin
                    an  <= AN_ONES;
                    seg <= dec_seg;
                    dp  <= (flash_cnt == 4'd0);
                end
                S_TENS: begin
                    if (tens_l) begin
                        an  <= AN_TENS;
                        seg <= dec_seg;
                    end else begin
                        an  <= AN_OFF;
                        seg <= SEG_BLANK;
                    end
                    dp <= 1'b1;
                end
                default: begin
                    an  <= AN_OFF;
                    seg <= SEG_BLANK;
                    dp  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_count_seg_display.sv
// tb/tb_count_seg_display.sv - self-checking bench for count_seg_display
module tb_count_seg_display;

    localparam int R  = 4;
    localparam int WF = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] count;
    logic [6:0] seg;
    logic [1:0] an;
    logic       dp;

    int n_checks = 0;
    int n_fail   = 0;

    count_seg_display #(
        .REFRESH_DIV (R),
        .WRAP_FLASH  (WF)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .count (count),
        .seg   (seg),
        .an    (an),
        .dp    (dp)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] dec_ref(input int d);
        case (d)
            0:       return 7'b1000000;
            1:       return 7'b1111001;
            2:       return 7'b0100100;
            3:       return 7'b0110000;
            4:       return 7'b0011001;
            5:       return 7'b0010010;
            6:       return 7'b0000010;
            7:       return 7'b1111000;
            8:       return 7'b0000000;
            9:       return 7'b0010000;
            default: return 7'h7F;
        endcase
    endfunction

    // Model: position in the frame comes from edges counted since reset
    logic       m_valid = 1'b0;
    int         m_edges = 0;
    logic [3:0] m_cq    = 4'd0;
    int         m_ones  = 0;
    logic       m_tens  = 1'b0;
    int         m_flash = 0;
    logic [6:0] e_seg;
    logic [1:0] e_an;
    logic       e_dp;

    wire m_in_tens  = (m_edges % (2 * R)) >= R;
    wire m_boundary = (m_edges % (2 * R)) == (2 * R - 1);
    wire m_wrap     = (m_cq == 4'd15) && (count == 4'd0);

    always @(posedge clk) begin
        if (reset) begin
            m_valid <= 1'b1;
            m_edges <= 0;
            m_cq    <= 4'd0;
            m_ones  <= 0;
            m_tens  <= 1'b0;
            m_flash <= 0;
            e_seg   <= 7'h7F;
            e_an    <= 2'b11;
            e_dp    <= 1'b1;
        end else begin
            e_an  <= m_in_tens ? (m_tens ? 2'b01 : 2'b11) : 2'b10;
            e_seg <= m_in_tens ? (m_tens ? dec_ref(1) : 7'h7F) : dec_ref(m_ones);
            e_dp  <= !(!m_in_tens && (m_flash != 0));
            if (m_boundary) begin
                m_tens <= (m_cq >= 4'd10);
                m_ones <= (m_cq >= 4'd10) ? int'(m_cq) - 10 : int'(m_cq);
            end
            m_flash <= m_wrap ? WF : ((m_boundary && m_flash != 0) ? m_flash - 1 : m_flash);
            m_cq    <= count;
            m_edges <= m_edges + 1;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            n_checks++;
            if (seg !== e_seg || an !== e_an || dp !== e_dp) begin
                n_fail++;
                $display("FAIL model t=%0t: seg=%b an=%b dp=%b, expected seg=%b an=%b dp=%b",
                         $time, seg, an, dp, e_seg, e_an, e_dp);
            end
        end
    end

    task automatic check_lit(input string name, input logic [6:0] s, input logic [1:0] a, input logic d);
        n_checks++;
        if (seg !== s || an !== a || dp !== d) begin
            n_fail++;
            $display("FAIL %s t=%0t: seg=%b an=%b dp=%b, expected seg=%b an=%b dp=%b",
                     name, $time, seg, an, dp, s, a, d);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        count = 4'd0;
        repeat (3) begin
            @(negedge clk);
            check_lit("reset_hold", 7'h7F, 2'b11, 1'b1);
        end
        reset = 1'b0;
        count = 4'd5;
        cycles(1);  check_lit("release_first", 7'b1000000, 2'b10, 1'b1);
        cycles(8);  check_lit("single_ones", 7'b0010010, 2'b10, 1'b1);
        cycles(4);  check_lit("single_tens", 7'h7F, 2'b11, 1'b1);
        count = 4'd12;
        cycles(4);  check_lit("two_ones", 7'b0100100, 2'b10, 1'b1);
        cycles(4);  check_lit("two_tens", 7'b1111001, 2'b01, 1'b1);
        count = 4'd3;
        cycles(5);  check_lit("mid_before", 7'b0110000, 2'b10, 1'b1);
        count = 4'd9;
        cycles(2);  check_lit("mid_hold", 7'b0110000, 2'b10, 1'b1);
        cycles(5);  check_lit("mid_after", 7'b0010000, 2'b10, 1'b1);
        cycles(5);  count = 4'd14;
        cycles(1);  count = 4'd15;
        cycles(1);  count = 4'd0;
        cycles(1);  check_lit("wrap_edge", 7'b0011001, 2'b10, 1'b1);
        cycles(1);  check_lit("wrap_dp_on", 7'b0011001, 2'b10, 1'b0);
        cycles(3);  check_lit("wrap_tens_dp_off", 7'b1111001, 2'b01, 1'b1);
        cycles(4);  check_lit("wrap_frame2", 7'b1000000, 2'b10, 1'b0);
        cycles(8);  check_lit("wrap_done", 7'b1000000, 2'b10, 1'b1);
        count = 4'd7;
        cycles(1);  count = 4'd0;
        cycles(8);  check_lit("no_wrap_dp", 7'b1000000, 2'b10, 1'b1);
        count = 4'd15;
        cycles(1);  count = 4'd0;
        cycles(6);  check_lit("flash_active", 7'b1000000, 2'b10, 1'b0);
        cycles(4);  reset = 1'b1;
        cycles(1);  check_lit("reset_in_flash", 7'h7F, 2'b11, 1'b1);
        reset = 1'b0;
        cycles(1);  check_lit("rerelease_first", 7'b1000000, 2'b10, 1'b1);
        cycles(8);  check_lit("flash_cleared", 7'b1000000, 2'b10, 1'b1);
        cycles(4);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
